risc16b_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous 64Ki x 8 (16-bit word) memory between the risc16b instruction port and data port.

---
 rtl/risc16b_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_risc16b_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc16b_mem_arbiter.sv
// risc16b_mem_arbiter
//   Shares one single-port synchronous 64Ki x 8 SRAM (16-bit words) between the risc16b
//   instruction and data ports, and decodes the IO_PAGE (addr[15:8]) to an MMIO bus.
//   One access is granted per cycle, combinationally from that cycle's requests; read
//   data returns one cycle after the grant.
//
// Optional feature: define RISC16B_ARB_FAIR_EN to cap consecutive data grants at
// MAX_D_STREAK while a fetch is waiting. Without it, data always wins.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   i_req/i_addr                 fetch request (held until i_gnt)
//   i_gnt/i_valid/i_rdata/i_err  fetch grant, response; i_err for fetches from IO_PAGE
//   d_req/d_addr/d_we/d_wdata    data request; d_we[0] -> bits 15:8, d_we[1] -> bits 7:0
//   d_gnt/d_valid/d_rdata        data grant, read response
//   m_*                          SRAM word port (m_rdata registered, 1 cycle after m_oe)
//   io_*                         MMIO port (io_rdata 1 cycle after io_oe)
module risc16b_mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter logic [7:0]  IO_PAGE      = 8'h7f
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_gnt,
  output logic        i_valid,
  output logic [15:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  input  logic [1:0]  d_we,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [15:0] d_rdata,
  output logic [14:0] m_addr,
  output logic        m_oe,
  output logic [1:0]  m_we,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  output logic [7:0]  io_addr,
  output logic        io_oe,
  output logic [1:0]  io_we,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata
);

  logic        d_win;
  logic        i_win;
  logic        force_i;
  logic [15:0] addr;
  logic        io_hit;
  logic        rd_grant;

  // Read owner: valid, port (1 = data), io (source bus; for fetches it flags the error)
  logic        rd_valid_q;
  logic        rd_port_q;
  logic        rd_io_q;
  logic [15:0] rd_src;
  logic [15:0] i_hold_q;
  logic [15:0] d_hold_q;

`ifdef RISC16B_ARB_FAIR_EN
  logic [2:0] streak_q;
  logic [2:0] streak_d;

  assign force_i = i_req && (32'(streak_q) >= MAX_D_STREAK);

  always_comb begin
    streak_d = streak_q;
    if (!i_req || i_win) begin
      streak_d = 3'd0;
    end else if (d_win && streak_q != 3'd7) begin
      streak_d = streak_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= 3'd0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  logic unused_max_d_streak;
  assign unused_max_d_streak = ^MAX_D_STREAK;
  assign force_i = 1'b0;
`endif

  always_comb begin
    d_win = 1'b0;
    i_win = 1'b0;
    if (!rst) begin
      if (d_req && !force_i) begin
        d_win = 1'b1;
      end else if (i_req) begin
        i_win = 1'b1;
      end
    end
  end

  assign d_gnt    = d_win;
  assign i_gnt    = i_win;
  assign addr     = d_win ? d_addr : i_addr;
  assign io_hit   = (addr[15:8] == IO_PAGE);
  assign rd_grant = i_win || (d_win && (d_we == 2'b00));

  always_comb begin
    m_addr   = '0;
    m_oe     = 1'b0;
    m_we     = '0;
    m_wdata  = '0;
    io_addr  = '0;
    io_oe    = 1'b0;
    io_we    = '0;
    io_wdata = '0;
    if (d_win) begin
      if (io_hit) begin
        io_addr  = addr[7:0];
        io_oe    = (d_we == 2'b00);
        io_we    = d_we;
        io_wdata = d_wdata;
      end else begin
        m_addr  = addr[15:1];
        m_oe    = (d_we == 2'b00);
        m_we    = d_we;
        m_wdata = d_wdata;
      end
    end else if (i_win && !io_hit) begin
      // Fetches from the MMIO page are never issued to the bus.
      m_addr = addr[15:1];
      m_oe   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_port_q  <= 1'b0;
      rd_io_q    <= 1'b0;
      i_hold_q   <= '0;
      d_hold_q   <= '0;
    end else begin
      rd_valid_q <= rd_grant;
      rd_port_q  <= d_win;
      rd_io_q    <= io_hit;
      i_hold_q   <= i_rdata;
      d_hold_q   <= d_rdata;
    end
  end

  assign rd_src  = rd_io_q ? io_rdata : m_rdata;
  assign i_valid = rd_valid_q && !rd_port_q && !rst;
  assign d_valid = rd_valid_q && rd_port_q && !rst;
  assign i_err   = i_valid && rd_io_q;

  always_comb begin
    i_rdata = i_hold_q;
    d_rdata = d_hold_q;
    if (rst) begin
      i_rdata = '0;
      d_rdata = '0;
    end else begin
      if (i_valid) begin
        i_rdata = rd_io_q ? 16'h0000 : rd_src;
      end
      if (d_valid) begin
        d_rdata = rd_src;
      end
    end
  end

endmodule

// File: tb/tb_risc16b_mem_arbiter.sv
module tb_risc16b_mem_arbiter;

`ifdef RISC16B_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int MAX_D_STREAK = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_gnt, i_valid, i_err;
  logic [15:0] i_rdata;
  logic        d_req = 1'b0;
  logic [15:0] d_addr = '0;
  logic [1:0]  d_we = '0;
  logic [15:0] d_wdata = '0;
  logic        d_gnt, d_valid;
  logic [15:0] d_rdata;
  logic [14:0] m_addr;
  logic        m_oe;
  logic [1:0]  m_we;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic [7:0]  io_addr;
  logic        io_oe;
  logic [1:0]  io_we;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;

  risc16b_mem_arbiter #(
    .MAX_D_STREAK(MAX_D_STREAK),
    .IO_PAGE     (8'h7f)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_gnt   (i_gnt),
    .i_valid (i_valid),
    .i_rdata (i_rdata),
    .i_err   (i_err),
    .d_req   (d_req),
    .d_addr  (d_addr),
    .d_we    (d_we),
    .d_wdata (d_wdata),
    .d_gnt   (d_gnt),
    .d_valid (d_valid),
    .d_rdata (d_rdata),
    .m_addr  (m_addr),
    .m_oe    (m_oe),
    .m_we    (m_we),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .io_addr (io_addr),
    .io_oe   (io_oe),
    .io_we   (io_we),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  // Environment: write-first synchronous SRAM and MMIO register file.
  bit [15:0] sram [0:32767];
  bit [15:0] ioreg [0:127];
  logic        load_en = 1'b0;
  logic [14:0] load_a = '0;
  logic [15:0] load_d = '0;

  always @(posedge clk) begin
    if (load_en) sram[load_a] <= load_d;
    if (m_we[0]) sram[m_addr][15:8] <= m_wdata[15:8];
    if (m_we[1]) sram[m_addr][7:0] <= m_wdata[7:0];
    if (m_oe) m_rdata <= sram[m_addr];
    if (io_we[0]) ioreg[io_addr[7:1]][15:8] <= io_wdata[15:8];
    if (io_we[1]) ioreg[io_addr[7:1]][7:0] <= io_wdata[7:0];
    if (io_oe) io_rdata <= ioreg[io_addr[7:1]];
  end

  // Reference model state
  bit [15:0] ref_mem [0:32767];
  bit [15:0] ref_io [0:127];
  bit        exp_iv, exp_dv, exp_ie;
  bit [15:0] exp_ir, exp_dr;
  int        streak;
  bit        cur_ig, cur_dg, cur_io;
  bit [15:0] cur_a, cur_wd;
  bit [1:0]  cur_we;

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests and compare all outputs at the falling edge.
  task automatic drive_chk(input bit ir, input bit [15:0] ia, input bit dr, input bit [15:0] da,
                           input bit [1:0] dwe, input bit [15:0] dwd);
    bit e_moe, e_iooe;
    bit [1:0] e_mwe, e_iowe;
    rst = 1'b0;
    i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_we = dwe; d_wdata = dwd;
    cur_dg = dr && !(FAIR && ir && streak >= MAX_D_STREAK);
    cur_ig = ir && !cur_dg;
    cur_a  = cur_dg ? da : ia;
    cur_io = (cur_a[15:8] == 8'h7f);
    cur_we = cur_dg ? dwe : 2'b00;
    cur_wd = dwd;
    e_moe = 0; e_iooe = 0; e_mwe = 0; e_iowe = 0;
    if (cur_dg) begin
      if (cur_io) begin e_iooe = (dwe == 2'b00); e_iowe = dwe; end
      else begin e_moe = (dwe == 2'b00); e_mwe = dwe; end
    end else if (cur_ig && !cur_io) begin
      e_moe = 1;
    end
    @(negedge clk);
    chk("i_gnt", 32'(i_gnt), 32'(cur_ig));
    chk("d_gnt", 32'(d_gnt), 32'(cur_dg));
    chk("m_oe", 32'(m_oe), 32'(e_moe));
    chk("m_we", 32'(m_we), 32'(e_mwe));
    chk("io_oe", 32'(io_oe), 32'(e_iooe));
    chk("io_we", 32'(io_we), 32'(e_iowe));
    if (e_moe || e_mwe != 0) chk("m_addr", 32'(m_addr), 32'(cur_a[15:1]));
    if (e_iooe || e_iowe != 0) chk("io_addr", 32'(io_addr), 32'(cur_a[7:0]));
    if (e_mwe != 0) chk("m_wdata", 32'(m_wdata), 32'(dwd));
    if (e_iowe != 0) chk("io_wdata", 32'(io_wdata), 32'(dwd));
    chk("i_valid", 32'(i_valid), 32'(exp_iv));
    chk("i_err", 32'(i_err), 32'(exp_ie));
    chk("i_rdata", 32'(i_rdata), 32'(exp_ir));
    chk("d_valid", 32'(d_valid), 32'(exp_dv));
    chk("d_rdata", 32'(d_rdata), 32'(exp_dr));
  endtask

  task automatic advance();
    bit [14:0] w;
    @(posedge clk);
    w = cur_a[15:1];
    exp_iv = 0; exp_dv = 0; exp_ie = 0;
    if (cur_ig) begin
      exp_iv = 1; exp_ie = cur_io;
      exp_ir = cur_io ? 16'h0000 : ref_mem[w];
    end
    if (cur_dg && cur_we == 2'b00) begin
      exp_dv = 1;
      exp_dr = cur_io ? ref_io[cur_a[7:1]] : ref_mem[w];
    end
    if (cur_dg && cur_we != 2'b00) begin
      if (cur_io) begin
        if (cur_we[0]) ref_io[cur_a[7:1]][15:8] = cur_wd[15:8];
        if (cur_we[1]) ref_io[cur_a[7:1]][7:0] = cur_wd[7:0];
      end else begin
        if (cur_we[0]) ref_mem[w][15:8] = cur_wd[15:8];
        if (cur_we[1]) ref_mem[w][7:0] = cur_wd[7:0];
      end
    end
    if (!i_req || cur_ig) streak = 0;
    else if (cur_dg && streak < 7) streak++;
    #1;
  endtask

  task automatic rst_cycle(input bit ir, input bit dr);
    rst = 1'b1;
    i_req = ir; i_addr = 16'h0010; d_req = dr; d_addr = 16'h0040; d_we = 2'b00;
    @(negedge clk);
    chk("rst_i_gnt", 32'(i_gnt), 0);
    chk("rst_d_gnt", 32'(d_gnt), 0);
    chk("rst_i_valid", 32'(i_valid), 0);
    chk("rst_d_valid", 32'(d_valid), 0);
    chk("rst_i_err", 32'(i_err), 0);
    chk("rst_strobes", 32'({m_oe, m_we, io_oe, io_we}), 0);
    chk("rst_addr", 32'({m_addr, io_addr}), 0);
    chk("rst_rdata", 32'({i_rdata, d_rdata}), 0);
    @(posedge clk);
    #1;
    load_en = 1'b0;
    exp_iv = 0; exp_dv = 0; exp_ie = 0; exp_ir = 0; exp_dr = 0; streak = 0;
  endtask

  function automatic bit [15:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return {8'h7f, 8'($urandom_range(0, 15))};
    return 16'($urandom_range(0, 63));
  endfunction

  typedef struct {
    bit ir; bit [15:0] ia; bit dr; bit [15:0] da; bit [1:0] dwe; bit [15:0] dwd;
    bit eig; bit edg; bit emoe; bit [1:0] emwe; bit eiooe; bit [1:0] eiowe;
    bit chk_ir; bit [15:0] eir; bit eie; bit chk_dr; bit [15:0] edr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int nd, ni;
    bit hir, hdr;
    bit [15:0] hia, hda, hwd;
    bit [1:0] hwe;

    //         ir ia       dr da       we     wd        ig dg moe mwe   iooe iowe  cir eir     eie cdr edr
    vecs[0] = '{1, 16'h0010, 1, 16'h0040, 2'b00, 16'h0000, 0, 1, 1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 16'h0010, 0, 16'h0000, 2'b00, 16'h0000, 1, 0, 1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0};
    vecs[2] = '{0, 16'h0000, 0, 16'h0000, 2'b00, 16'h0000, 0, 0, 0, 2'b00, 0, 2'b00,
                1, 16'hA55A, 0, 0, 0};
    vecs[3] = '{0, 16'h0000, 1, 16'h0020, 2'b11, 16'hFFFF, 0, 1, 0, 2'b11, 0, 2'b00, 0, 0, 0, 0, 0};
    vecs[4] = '{0, 16'h0000, 1, 16'h0020, 2'b01, 16'h1234, 0, 1, 0, 2'b01, 0, 2'b00, 0, 0, 0, 0, 0};
    vecs[5] = '{0, 16'h0000, 1, 16'h0020, 2'b00, 16'h0000, 0, 1, 1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0};
    vecs[6] = '{1, 16'h0010, 1, 16'h7f00, 2'b11, 16'h00C3, 0, 1, 0, 2'b00, 0, 2'b11,
                0, 0, 0, 1, 16'h12FF};
    vecs[7] = '{1, 16'h7f02, 0, 16'h0000, 2'b00, 16'h0000, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0};
    vecs[8] = '{0, 16'h0000, 1, 16'h7f00, 2'b00, 16'h0000, 0, 1, 0, 2'b00, 1, 2'b00,
                1, 16'h0000, 1, 0, 0};
    vecs[9] = '{0, 16'h0000, 0, 16'h0000, 2'b00, 16'h0000, 0, 0, 0, 2'b00, 0, 2'b00,
                0, 0, 0, 1, 16'h00C3};

    // Preset word 0x0010 during reset, then hold reset 3 cycles with both requests up.
    load_en = 1'b1; load_a = 15'h0008; load_d = 16'hA55A;
    ref_mem[15'h0008] = 16'hA55A;
    rst_cycle(0, 0);
    for (int k = 0; k < 3; k++) rst_cycle(1, 1);

    for (int k = 0; k < 10; k++) begin
      drive_chk(vecs[k].ir, vecs[k].ia, vecs[k].dr, vecs[k].da, vecs[k].dwe, vecs[k].dwd);
      chk($sformatf("v%0d_gnt", k), 32'({i_gnt, d_gnt}), 32'({vecs[k].eig, vecs[k].edg}));
      chk($sformatf("v%0d_mem", k), 32'({m_oe, m_we}), 32'({vecs[k].emoe, vecs[k].emwe}));
      chk($sformatf("v%0d_io", k), 32'({io_oe, io_we}), 32'({vecs[k].eiooe, vecs[k].eiowe}));
      if (vecs[k].emoe || vecs[k].emwe != 0 || (vecs[k].eig && vecs[k].emoe))
        chk($sformatf("v%0d_m_addr", k), 32'(m_addr), 32'(vecs[k].edg ? vecs[k].da[15:1]
                                                                         : vecs[k].ia[15:1]));
      if (vecs[k].eiooe || vecs[k].eiowe != 0)
        chk($sformatf("v%0d_io_addr", k), 32'(io_addr), 32'h00);
      if (vecs[k].chk_ir)
        chk($sformatf("v%0d_ifetch", k), 32'({i_valid, i_err, i_rdata}),
            32'({1'b1, vecs[k].eie, vecs[k].eir}));
      if (vecs[k].chk_dr)
        chk($sformatf("v%0d_dread", k), 32'({d_valid, d_rdata}), 32'({1'b1, vecs[k].edr}));
      advance();
    end

    // Both ports reading for 10 cycles.
    nd = 0; ni = 0;
    for (int k = 0; k < 10; k++) begin
      drive_chk(1, 16'h0010, 1, 16'h0040, 2'b00, 16'h0000);
      chk("streak_d_gnt", 32'(d_gnt), 32'(FAIR ? (k % 5 != 4) : 1'b1));
      nd += int'(d_gnt); ni += int'(i_gnt);
      advance();
    end
    chk("d_gnt_count", 32'(nd), FAIR ? 32'd8 : 32'd10);
    chk("i_gnt_count", 32'(ni), FAIR ? 32'd2 : 32'd0);

    // Read granted, reset in the following cycle: response must be dropped.
    drive_chk(0, 16'h0000, 1, 16'h0040, 2'b00, 16'h0000);
    advance();
    rst_cycle(0, 0);
    drive_chk(0, 16'h0000, 0, 16'h0000, 2'b00, 16'h0000);
    chk("drop_d_valid", 32'(d_valid), 0);
    advance();

    // Randomized traffic with held requests.
    hir = 0; hdr = 0; hia = 0; hda = 0; hwd = 0; hwe = 0;
    for (int k = 0; k < 400; k++) begin
      if (!hir && $urandom_range(0, 2) != 0) begin hir = 1; hia = rnd_addr(); end
      if (!hdr && $urandom_range(0, 1) != 0) begin
        hdr = 1; hda = rnd_addr(); hwd = 16'($urandom);
        hwe = ($urandom_range(0, 1) != 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
      drive_chk(hir, hia, hdr, hda, hwe, hwd);
      advance();
      if (cur_ig) hir = 0;
      if (cur_dg) hdr = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
